// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_cmd_sequencer: valid/ready command front-end for an 8-bit comb. ALU   |
// | with result accumulator, chaining, zero flag and op counter.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             exec_done;
  logic             rsp_done;
  logic [WIDTH-1:0] accumulator;

  // Gated by rst_n so no command can be taken while reset is held.
  assign cmd_ready = (state == IDLE) & rst_n;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    exec_done  = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        exec_done  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 2'b00;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      accumulator <= '0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_chain ? accumulator : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      // The ALU has had the whole EXEC cycle to settle on the registered operands.
      if (exec_done) begin
        rsp_result  <= alu_result;
        accumulator <= alu_result;
        rsp_zero    <= (alu_result == '0);
        op_count    <= op_count + CNT_W'(1);
        rsp_valid   <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// Bench for alu_cmd_sequencer: table of single commands plus directed
// sequences for backpressure, reset during EXEC and op_count wrap.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;

  int n_vec;
  int n_fail;
  int exp_count;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic [7:0] exp_a;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; rsp_ready is held high throughout.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic chain,
                         input logic [7:0] exp_a, input logic [7:0] exp_res);
    int wait_cyc;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check({name, " ready"}, 32'(cmd_ready), 32'd1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({name, " alu_a"}, 32'(alu_a), 32'(exp_a));
    check({name, " alu_b"}, 32'(alu_b), 32'(b));
    check({name, " alu_op"}, 32'(alu_op), 32'(op));
    check({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, " exec cmd_ready"}, 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    exp_count = (exp_count + 1) % 256;
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
    check({name, " rsp_zero"}, 32'(rsp_zero), 32'(exp_res == 8'd0));
    check({name, " op_count"}, 32'(op_count), 32'(exp_count));
    @(posedge clk); #1;
    check({name, " rsp done"}, 32'(rsp_valid), 32'd0);
    check({name, " ready again"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic quick_add;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'd1; cmd_b = 8'd1; cmd_chain = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_count = (exp_count + 1) % 256;
  endtask

  initial begin
    n_vec = 0; n_fail = 0; exp_count = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; rsp_ready = 1'b0;

    vecs[0] = '{"add10+5",   2'b00, 8'd10,  8'd5,   1'b0, 8'd10,  8'd15};
    vecs[1] = '{"sub100-40", 2'b01, 8'd100, 8'd40,  1'b0, 8'd100, 8'd60};
    vecs[2] = '{"chainsub",  2'b01, 8'd99,  8'd60,  1'b1, 8'd60,  8'd0};
    vecs[3] = '{"sub5-10",   2'b01, 8'd5,   8'd10,  1'b0, 8'd5,   8'd251};
    vecs[4] = '{"add200+100",2'b00, 8'd200, 8'd100, 1'b0, 8'd200, 8'd44};
    vecs[5] = '{"andCC.AA",  2'b10, 8'hCC,  8'hAA,  1'b0, 8'hCC,  8'h88};
    vecs[6] = '{"orCC.AA",   2'b11, 8'hCC,  8'hAA,  1'b0, 8'hCC,  8'hEE};
    vecs[7] = '{"chainadd",  2'b00, 8'h55,  8'h12,  1'b1, 8'hEE,  8'h00};
    vecs[8] = '{"chainadd1", 2'b00, 8'h55,  8'h01,  1'b1, 8'h00,  8'h01};
    vecs[9] = '{"andFF.0F",  2'b10, 8'hFF,  8'h0F,  1'b0, 8'hFF,  8'h0F};

    #12;
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset op_count", 32'(op_count), 32'd0);
    check("reset alu_a", 32'(alu_a), 32'd0);
    check("reset rsp_zero", 32'(rsp_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain,
              vecs[i].exp_a, vecs[i].exp_res);

    // Backpressure: first response held 5 cycles while a second command waits.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'd3; cmd_b = 8'd4; cmd_chain = 1'b0;
    @(posedge clk); #1;
    cmd_op = 2'b01; cmd_a = 8'd50; cmd_b = 8'd8;
    @(posedge clk); #1;
    exp_count++;
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_result", 32'(rsp_result), 32'd7);
      check("bp cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp alu_a held", 32'(alu_a), 32'd3);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp handshake", 32'(rsp_valid), 32'd0);
    check("bp not yet taken", 32'(alu_a), 32'd3);
    check("bp ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp 2nd alu_a", 32'(alu_a), 32'd50);
    check("bp 2nd alu_op", 32'(alu_op), 32'd1);
    @(posedge clk); #1;
    exp_count++;
    check("bp 2nd result", 32'(rsp_result), 32'd42);
    check("bp 2nd count", 32'(op_count), 32'(exp_count));
    @(posedge clk); #1;

    // Reset pulled while in EXEC aborts the operation.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'd9; cmd_b = 8'd9; cmd_chain = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstx rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstx op_count", 32'(op_count), 32'd0);
    check("rstx alu_a", 32'(alu_a), 32'd0);
    check("rstx alu_b", 32'(alu_b), 32'd0);
    check("rstx alu_op", 32'(alu_op), 32'd0);
    check("rstx cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstx no rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    exp_count = 0;
    run_cmd("post-reset chain", 2'b00, 8'hAA, 8'd7, 1'b1, 8'd0, 8'd7);

    // Drive op_count to 255, then one more wraps to 0.
    while (exp_count < 255) quick_add();
    check("count 255", 32'(op_count), 32'd255);
    quick_add();
    check("count wrap", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
